// File: rtl/kf_s_inv_serial.sv
// Innovation covariance S = P_pred + R (H = I, 2x2) and its inverse S^-1 in N.FRAC fixed point.
// The inverse is adj(S) scaled by a reciprocal of |det| from a bit-serial restoring divider.
module kf_s_inv_serial #(
  parameter int unsigned N    = 20,
  parameter int unsigned FRAC = 10,
  parameter int unsigned D_W  = 3 * FRAC + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] P11,
  input  logic signed [N-1:0] P12,
  input  logic signed [N-1:0] P21,
  input  logic signed [N-1:0] P22,
  input  logic signed [N-1:0] R11,
  input  logic signed [N-1:0] R22,
  output logic                busy,
  output logic                done,
  output logic                singular,
  output logic signed [N-1:0] S11,
  output logic signed [N-1:0] S12,
  output logic signed [N-1:0] S21,
  output logic signed [N-1:0] S22,
  output logic signed [N-1:0] Si11,
  output logic signed [N-1:0] Si12,
  output logic signed [N-1:0] Si21,
  output logic signed [N-1:0] Si22
);

  localparam int unsigned DetW  = 2 * N + 1;
  localparam int unsigned ProdW = N + D_W + 2;
  localparam int unsigned CntW  = $clog2(D_W + 1);
  localparam logic [D_W-1:0] DvdInit = D_W'(1) << (3 * FRAC);

  typedef enum logic [2:0] {StIdle, StSum, StDet, StDiv, StMul} state_e;

  state_e              state_q, state_d;
  logic signed [N-1:0] p11_q, p12_q, p21_q, p22_q, r11_q, r22_q;
  logic signed [N-1:0] p11_d, p12_d, p21_d, p22_d, r11_d, r22_d;
  logic signed [N-1:0] s11_q, s12_q, s21_q, s22_q, s11_d, s12_d, s21_d, s22_d;
  logic signed [N-1:0] si11_q, si12_q, si21_q, si22_q, si11_d, si12_d, si21_d, si22_d;
  logic                det_sign_q, det_sign_d;
  logic [DetW-1:0]     det_abs_q, det_abs_d;
  logic [DetW-1:0]     rem_q, rem_d;
  logic [D_W-1:0]      dvd_q, dvd_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d, singular_q, singular_d;

  logic signed [DetW-1:0] e11, e12, e21, e22, det;
  logic [DetW-1:0]        det_mag;
  logic [DetW:0]          rem_sh;
  logic                   rem_ge;

  function automatic logic signed [N-1:0] sat_add(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
    logic signed [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    if (s[N] != s[N-1]) begin
      sat_add = s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      sat_add = s[N-1:0];
    end
  endfunction

  // adj * q, sign-corrected, floor-shifted back to N.FRAC and saturated.
  function automatic logic signed [N-1:0] mul_si(input logic signed [N:0] adj,
                                                 input logic [D_W-1:0]    q,
                                                 input logic              neg);
    logic signed [ProdW-1:0] a, b, p;
    logic [ProdW-N:0]        top;
    a = {{(ProdW-N-1){adj[N]}}, adj};
    b = {{(ProdW-D_W){1'b0}}, q};
    p = a * b;
    if (neg) p = -p;
    p = p >>> FRAC;
    top = p[ProdW-1:N-1];
    if (top == '0 || top == '1) begin
      mul_si = p[N-1:0];
    end else begin
      mul_si = p[ProdW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  endfunction

  always_comb begin
    e11     = {{(DetW-N){s11_q[N-1]}}, s11_q};
    e12     = {{(DetW-N){s12_q[N-1]}}, s12_q};
    e21     = {{(DetW-N){s21_q[N-1]}}, s21_q};
    e22     = {{(DetW-N){s22_q[N-1]}}, s22_q};
    det     = e11 * e22 - e12 * e21;
    det_mag = det[DetW-1] ? -det : det;
    rem_sh  = {rem_q, dvd_q[D_W-1]};
    rem_ge  = rem_sh >= {1'b0, det_abs_q};
  end

  always_comb begin
    state_d    = state_q;
    p11_d      = p11_q;
    p12_d      = p12_q;
    p21_d      = p21_q;
    p22_d      = p22_q;
    r11_d      = r11_q;
    r22_d      = r22_q;
    s11_d      = s11_q;
    s12_d      = s12_q;
    s21_d      = s21_q;
    s22_d      = s22_q;
    si11_d     = si11_q;
    si12_d     = si12_q;
    si21_d     = si21_q;
    si22_d     = si22_q;
    det_sign_d = det_sign_q;
    det_abs_d  = det_abs_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    singular_d = singular_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          p11_d      = P11;
          p12_d      = P12;
          p21_d      = P21;
          p22_d      = P22;
          r11_d      = R11;
          r22_d      = R22;
          busy_d     = 1'b1;
          singular_d = 1'b0;
          state_d    = StSum;
        end
      end
      StSum: begin
        s11_d   = sat_add(p11_q, r11_q);
        s22_d   = sat_add(p22_q, r22_q);
        s12_d   = p12_q;
        s21_d   = p21_q;
        state_d = StDet;
      end
      StDet: begin
        det_sign_d = det[DetW-1];
        det_abs_d  = det_mag;
        if (det == '0) begin
          si11_d     = '0;
          si12_d     = '0;
          si21_d     = '0;
          si22_d     = '0;
          singular_d = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else begin
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = DvdInit;
          state_d = StDiv;
        end
      end
      StDiv: begin
        // Dividend shifts out MSB-first while quotient bits shift in behind it.
        rem_d = rem_ge ? DetW'(rem_sh - {1'b0, det_abs_q}) : rem_sh[DetW-1:0];
        dvd_d = {dvd_q[D_W-2:0], rem_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(D_W - 1)) state_d = StMul;
      end
      StMul: begin
        si11_d  = mul_si({s22_q[N-1], s22_q}, dvd_q, det_sign_q);
        si12_d  = mul_si(-{s12_q[N-1], s12_q}, dvd_q, det_sign_q);
        si21_d  = mul_si(-{s21_q[N-1], s21_q}, dvd_q, det_sign_q);
        si22_d  = mul_si({s11_q[N-1], s11_q}, dvd_q, det_sign_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p11_q      <= '0;
      p12_q      <= '0;
      p21_q      <= '0;
      p22_q      <= '0;
      r11_q      <= '0;
      r22_q      <= '0;
      s11_q      <= '0;
      s12_q      <= '0;
      s21_q      <= '0;
      s22_q      <= '0;
      si11_q     <= '0;
      si12_q     <= '0;
      si21_q     <= '0;
      si22_q     <= '0;
      det_sign_q <= 1'b0;
      det_abs_q  <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      singular_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p11_q      <= p11_d;
      p12_q      <= p12_d;
      p21_q      <= p21_d;
      p22_q      <= p22_d;
      r11_q      <= r11_d;
      r22_q      <= r22_d;
      s11_q      <= s11_d;
      s12_q      <= s12_d;
      s21_q      <= s21_d;
      s22_q      <= s22_d;
      si11_q     <= si11_d;
      si12_q     <= si12_d;
      si21_q     <= si21_d;
      si22_q     <= si22_d;
      det_sign_q <= det_sign_d;
      det_abs_q  <= det_abs_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      singular_q <= singular_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = singular_q;
  assign S11      = s11_q;
  assign S12      = s12_q;
  assign S21      = s21_q;
  assign S22      = s22_q;
  assign Si11     = si11_q;
  assign Si12     = si12_q;
  assign Si21     = si21_q;
  assign Si22     = si22_q;

endmodule

// File: tb/tb_kf_s_inv_serial.sv
// Scoreboard bench for kf_s_inv_serial: a reference model queues expected S, S^-1, singular
// and latency at each start; a monitor pops and compares on every done pulse.
module tb_kf_s_inv_serial;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int D_W  = 3 * FRAC + 1;
  localparam longint MaxV = (longint'(1) <<< (N - 1)) - 1;
  localparam longint MinV = -(longint'(1) <<< (N - 1));

  logic                clk, rst_n, start;
  logic signed [N-1:0] P11, P12, P21, P22, R11, R22;
  logic                busy, done, singular;
  logic signed [N-1:0] S11, S12, S21, S22, Si11, Si12, Si21, Si22;

  kf_s_inv_serial #(.N(N), .FRAC(FRAC), .D_W(D_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .P11(P11), .P12(P12), .P21(P21), .P22(P22), .R11(R11), .R22(R22),
    .busy(busy), .done(done), .singular(singular),
    .S11(S11), .S12(S12), .S21(S21), .S22(S22),
    .Si11(Si11), .Si12(Si12), .Si21(Si21), .Si22(Si22)
  );

  typedef struct {
    longint s11, s12, s21, s22;
    longint i11, i12, i21, i22;
    bit     sing;
    int     lat;
    int     t0;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > MaxV) return MaxV;
    if (v < MinV) return MinV;
    return v;
  endfunction

  function automatic longint scale(input longint a, input longint q, input bit neg);
    longint p;
    p = a * q;
    if (neg) p = -p;
    return sat(p >>> FRAC);
  endfunction

  function automatic exp_t model(input longint p11, p12, p21, p22, r11, r22);
    exp_t   e;
    longint det, ad, q;
    bit     neg;
    e.s11 = sat(p11 + r11);
    e.s22 = sat(p22 + r22);
    e.s12 = p12;
    e.s21 = p21;
    det   = e.s11 * e.s22 - e.s12 * e.s21;
    e.sing = (det == 0);
    e.lat  = e.sing ? 2 : D_W + 3;
    e.t0   = 0;
    e.i11 = 0; e.i12 = 0; e.i21 = 0; e.i22 = 0;
    if (!e.sing) begin
      neg = det < 0;
      ad  = neg ? -det : det;
      q   = (longint'(1) <<< (3 * FRAC)) / ad;
      e.i11 = scale(e.s22, q, neg);
      e.i12 = scale(-e.s12, q, neg);
      e.i21 = scale(-e.s21, q, neg);
      e.i22 = scale(e.s11, q, neg);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_seen++;
      check_eq("pending_result", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("S11", S11, e.s11);
        check_eq("S12", S12, e.s12);
        check_eq("S21", S21, e.s21);
        check_eq("S22", S22, e.s22);
        check_eq("Si11", Si11, e.i11);
        check_eq("Si12", Si12, e.i12);
        check_eq("Si21", Si21, e.i21);
        check_eq("Si22", Si22, e.i22);
        check_eq("singular", singular, longint'(e.sing));
        check_eq("busy_at_done", busy, 0);
        check_eq("latency", cyc - e.t0, e.lat);
      end
    end
  end

  // now=1 drives within the current cycle (caller already sits just after a negedge).
  task automatic drive(input longint p11, p12, p21, p22, r11, r22, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    #2;
    P11 = p11[N-1:0]; P12 = p12[N-1:0]; P21 = p21[N-1:0];
    P22 = p22[N-1:0]; R11 = r11[N-1:0]; R22 = r22[N-1:0];
    e = model(longint'(P11), longint'(P12), longint'(P21), longint'(P22),
              longint'(R11), longint'(R22));
    e.t0 = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    check_eq("busy_after_start", busy, 1);
    check_eq("singular_cleared", singular, 0);
    #2 start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) return;
    end
    check_eq("timeout_idle", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (done) return;
    end
    check_eq("timeout_done", done, 1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_singular"}, singular, 0);
    check_eq({tag, "_S11"}, S11, 0);
    check_eq({tag, "_S12"}, S12, 0);
    check_eq({tag, "_S21"}, S21, 0);
    check_eq({tag, "_S22"}, S22, 0);
    check_eq({tag, "_Si11"}, Si11, 0);
    check_eq({tag, "_Si12"}, Si12, 0);
    check_eq({tag, "_Si21"}, Si21, 0);
    check_eq({tag, "_Si22"}, Si22, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish by 1ms");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    P11 = '0; P12 = '0; P21 = '0; P22 = '0; R11 = '0; R22 = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    drive(1024, 0, 0, 1024, 1024, 1024, 1'b0);
    wait_idle();
    // Back-to-back: next start issued in the done cycle.
    drive(2048, 512, 512, 1024, 1024, 1024, 1'b0);
    wait_done();
    drive(0, 0, 0, 0, 0, 0, 1'b1);
    wait_idle();
    drive(524287, 0, 0, 1024, 1024, 0, 1'b0);
    wait_idle();
    drive(0, 2048, 2048, 0, 0, 0, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      drive(longint'($urandom), longint'($urandom), longint'($urandom),
            longint'($urandom), longint'($urandom), longint'($urandom), 1'b0);
      wait_idle();
    end

    // Reset mid-divide: outputs clear, pending result never arrives.
    drive(1024, 0, 0, 1024, 1024, 1024, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    sb.delete();
    #2 rst_n = 1'b1;
    base = done_seen;
    repeat (40) @(negedge clk);
    check_eq("no_done_after_reset", done_seen, base);

    // A start while busy is ignored: one done, carrying the first request's result.
    base = done_seen;
    drive(1024, 0, 0, 1024, 1024, 1024, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    P11 = 20'sd2048; P12 = 20'sd512; P21 = 20'sd512; R11 = 20'sd7;
    start = 1'b1;
    @(negedge clk);
    #2 start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check_eq("single_done_when_busy_start", done_seen, base + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kf_s_inv_serial.md
# kf_s_inv_serial

Computes the Kalman innovation covariance S = P_pred + R (H = I, 2x2) and its inverse S⁻¹ in N.FRAC fixed point. It sits directly downstream of the measurement-noise stage and consumes that stage's diagonal R11/R22 together with the predicted covariance. It produces S and S⁻¹ for the Kalman-gain stage. The inverse uses the adjugate divided by a determinant; the reciprocal comes from a one-bit-per-cycle restoring divider.

## Interface
Parameters:
- N, 20, total signed width of all data ports.
- FRAC, 10, fractional bits; 1.0 = 2^FRAC.
- D_W, 3*FRAC+1, dividend/quotient width of the serial divider; also the number of divide cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- P11, P12, P21, P22  in  N signed  predicted covariance; captured on accepted start.
- R11, R22  in  N signed  measurement noise diagonal; captured on accepted start. R12 = R21 = 0 implicitly.
- busy  out  1  high from the edge after an accepted start until done.
- done  out  1  one-cycle pulse when outputs are valid.
- singular  out  1  set with done when det = 0; cleared on the next accepted start.
- S11, S12, S21, S22  out  N signed  registered S.
- Si11, Si12, Si21, Si22  out  N signed  registered S⁻¹.

## Operation
- Reset (rst_n = 0 at a rising edge): all outputs = 0, FSM = IDLE, divider cleared. Reset has priority in every state, including mid-divide.
- States: IDLE → SUM → DET → DIV → MUL → IDLE.
- IDLE: on start = 1, capture P and R, set busy = 1 and clear singular. Go to SUM. While not IDLE, start is ignored.
- SUM: compute S11 = sat(P11+R11), S22 = sat(P22+R22), S12 = P12, S21 = P21. Addition is done at N+1 bits and saturated to [-2^(N-1), 2^(N-1)-1]. Go to DET.
- DET: compute det = S11*S22 − S12*S21 at 2N+1 bits; det carries 2·FRAC fractional bits. Register det_sign and |det|.
  - If det = 0: set Si = 0, singular = 1, done = 1, busy = 0, and go to IDLE.
  - Otherwise go to DIV and clear the count.
- DIV: unsigned restoring divide of the constant 2^(3·FRAC) by |det|, one quotient bit per cycle, MSB first, for D_W cycles. The quotient q is floor(2^(3·FRAC)/|det|), which is 1/|det| in N.FRAC. After the D_W-th step, go to MUL.
- MUL: form adj = (S22, −S12, −S21, S11). Each prod = adj_ij * q, signed, at N+D_W+1 bits.
  - If det_sign = 1, negate prod.
  - Arithmetic-shift prod right by FRAC (floor), then saturate to N bits to give Si_ij.
  - Set done = 1 and busy = 0; go to IDLE.
- The S outputs update at the SUM edge and hold until the next accepted start's SUM edge.

## Timing
- Edge 0 samples start. Edge 1 is SUM, edge 2 is DET, edges 3..D_W+2 are DIV, and edge D_W+3 is MUL, which sets done.
- Latency start→done = D_W+3 edges (34 at defaults). The singular path takes 2 edges.
- done is high for exactly one cycle. A start in the cycle done is high is accepted, because the FSM is in IDLE.
- busy = 0 in the same cycle done = 1.
- Back-to-back throughput: one result per D_W+4 cycles.

## Test plan
- P = (1024, 0, 0, 1024), R11 = R22 = 1024 → S = (2048, 0, 0, 2048), det = 2^22, q = 256, Si = (512, 0, 0, 512). done exactly 34 cycles after start; singular = 0.
- P = (2048, 512, 512, 1024), R = (1024, 1024) → S = (3072, 512, 512, 2048), det = 6029312, q = 178, Si = (356, −89, −89, 534).
- All P = 0 and R = 0 → singular = 1, Si all 0, done 2 edges after start; the next valid start clears singular.
- P11 = 524287, P12 = P21 = 0, P22 = 1024, R11 = 1024, R22 = 0 → S11 saturates to 524287, q = 2, Si11 = 2, Si22 = 1023, off-diagonals 0.
- P = (0, 2048, 2048, 0), R = 0 → det = −4194304, q = 256, Si = (0, 512, 512, 0).
- Start, then rst_n = 0 for one edge mid-DIV → all outputs 0 and busy = 0 next cycle, and no done pulse. A start pulsed while busy is ignored, with no extra done. A fresh start then yields the correct result of scenario 1.
